// File: rtl/clk_rst_seq.sv
// clk_rst_seq
//   Reset and clock-enable sequencer that sits directly downstream of the
//   system PLL in the clk_sys domain. It synchronises the PLL lock flag and
//   holds everything in reset until the lock has been stable for a settle
//   period. It then releases the video, CPU and audio resets in that order,
//   each release landing on a ce_3m strobe. It also produces phase-aligned
//   12/6/3 MHz clock-enable strobes from the 36 MHz clk_sys.
//
// Ports
//   clk_sys    in   system clock from the PLL
//   rst        in   asynchronous active-high reset
//   pll_locked in   PLL lock flag, asynchronous to clk_sys
//   soft_rst   in   synchronous soft-reset request (OSD / ROM download)
//   ce_12m     out  one-cycle strobe every 3 clk_sys
//   ce_6m      out  one-cycle strobe every 6 clk_sys
//   ce_3m      out  one-cycle strobe every 12 clk_sys
//   rst_video  out  active-high video reset
//   rst_cpu    out  active-high CPU reset
//   rst_audio  out  active-high audio reset
//   ready      out  high only once the whole sequence has completed (RUN)

module clk_rst_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4096,
  parameter int STAGE_GAP     = 16
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_rst,
  output logic ce_12m,
  output logic ce_6m,
  output logic ce_3m,
  output logic rst_video,
  output logic rst_cpu,
  output logic rst_audio,
  output logic ready
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SETTLE,
    REL_V,
    GAP_C,
    REL_C,
    GAP_A,
    REL_A,
    RUN
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [3:0]             ph;
  logic [3:0]             ph_inc;
  logic [SW-1:0]          settle_cnt, settle_next;
  logic [GW-1:0]          gap_cnt, gap_next;
  logic                   running;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign ph_inc   = (ph == 4'd11) ? 4'd0 : ph + 4'd1;

  // Strobes are only generated while the sequencer is out of WAIT_LOCK and
  // is not about to fall back into it, so a lock loss stops them at once.
  assign running  = (state != WAIT_LOCK) && (state_next != WAIT_LOCK);

  // Plain shift-register synchroniser for the asynchronous lock flag.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // State, counter and phase registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      gap_cnt    <= '0;
      ph         <= 4'd0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      gap_cnt    <= gap_next;
      ph         <= (state == WAIT_LOCK || state_next == WAIT_LOCK) ? 4'd0 : ph_inc;
    end
  end

  // Next-state logic. Lock loss beats soft reset, and both beat the normal
  // progression. The release states wait for ph==0 because that is the
  // cycle whose registered decode drives ce_3m high, so each reset edge
  // appears in the same cycle as a ce_3m strobe.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    gap_next    = gap_cnt;
    if (state != WAIT_LOCK && !locked_s) begin
      state_next  = WAIT_LOCK;
      settle_next = '0;
      gap_next    = '0;
    end else if (state != WAIT_LOCK && soft_rst) begin
      state_next  = SETTLE;
      settle_next = '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next  = SETTLE;
            settle_next = '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_next = REL_V;
          end else begin
            settle_next = settle_cnt + 1'b1;
          end
        end
        REL_V: begin
          if (ph == 4'd0) begin
            state_next = GAP_C;
            gap_next   = '0;
          end
        end
        GAP_C: begin
          if (gap_cnt == GAP_LAST) begin
            state_next = REL_C;
          end else begin
            gap_next = gap_cnt + 1'b1;
          end
        end
        REL_C: begin
          if (ph == 4'd0) begin
            state_next = GAP_A;
            gap_next   = '0;
          end
        end
        GAP_A: begin
          if (gap_cnt == GAP_LAST) begin
            state_next = REL_A;
          end else begin
            gap_next = gap_cnt + 1'b1;
          end
        end
        REL_A: begin
          if (ph == 4'd0) begin
            state_next = RUN;
          end
        end
        RUN: begin
          state_next = RUN;
        end
        default: begin
          state_next = WAIT_LOCK;
        end
      endcase
    end
  end

  // Registered outputs. Reset outputs are decoded from the next state so
  // every re-entry into reset raises all three in the same cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rst_video <= 1'b1;
      rst_cpu   <= 1'b1;
      rst_audio <= 1'b1;
      ready     <= 1'b0;
      ce_12m    <= 1'b0;
      ce_6m     <= 1'b0;
      ce_3m     <= 1'b0;
    end else begin
      rst_video <= (state_next inside {WAIT_LOCK, SETTLE, REL_V});
      rst_cpu   <= (state_next inside {WAIT_LOCK, SETTLE, REL_V, GAP_C, REL_C});
      rst_audio <= (state_next != RUN);
      ready     <= (state_next == RUN);
      ce_12m    <= running && (ph inside {4'd0, 4'd3, 4'd6, 4'd9});
      ce_6m     <= running && (ph inside {4'd0, 4'd6});
      ce_3m     <= running && (ph == 4'd0);
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq
//   Self-checking bench for clk_rst_seq with SETTLE_CYCLES=64, STAGE_GAP=8,
//   SYNC_STAGES=2. Expected behaviour is expressed as timing windows and
//   ordering relations measured in clk_sys cycles from the stimulus events.

module tb_clk_rst_seq;

  localparam int SETTLE = 64;
  localparam int GAP    = 8;
  localparam int SYNC   = 2;

  logic clk_sys;
  logic rst;
  logic pll_locked;
  logic soft_rst;
  logic ce_12m, ce_6m, ce_3m;
  logic rst_video, rst_cpu, rst_audio, ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clk_rst_seq #(
    .SYNC_STAGES  (SYNC),
    .SETTLE_CYCLES(SETTLE),
    .STAGE_GAP    (GAP)
  ) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pll_locked(pll_locked),
    .soft_rst  (soft_rst),
    .ce_12m    (ce_12m),
    .ce_6m     (ce_6m),
    .ce_3m     (ce_3m),
    .rst_video (rst_video),
    .rst_cpu   (rst_cpu),
    .rst_audio (rst_audio),
    .ready     (ready)
  );

  // Free-running clock and a cycle index counting active edges.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [6:0] outs();
    return {rst_video, rst_cpu, rst_audio, ready, ce_12m, ce_6m, ce_3m};
  endfunction

  // Follows a full release sequence starting from the all-in-reset state.
  // The video release must land in [lo, hi], every release must coincide
  // with a ce_3m strobe, the later releases follow 12 or 24 cycles apart,
  // ready rises with the audio release and the order is never violated.
  task automatic check_sequence(input string tag, input int lo, input int hi);
    int   tv, tc, ta, tr, bad, n;
    logic cv, cc, ca;
    logic pv, pc, pa, pr;
    tv = -1; tc = -1; ta = -1; tr = -1; bad = 0; n = 0;
    cv = 1'b0; cc = 1'b0; ca = 1'b0;
    pv = rst_video; pc = rst_cpu; pa = rst_audio; pr = ready;
    while (ta < 0 && n < 300) begin
      @(negedge clk_sys);
      n++;
      if (pv && !rst_video) begin tv = cyc; cv = ce_3m; end
      if (pc && !rst_cpu)   begin tc = cyc; cc = ce_3m; end
      if (pa && !rst_audio) begin ta = cyc; ca = ce_3m; end
      if (!pr && ready) tr = cyc;
      if ((!rst_cpu && rst_video) || (!rst_audio && rst_cpu) || (ready !== !rst_audio))
        bad++;
      pv = rst_video; pc = rst_cpu; pa = rst_audio; pr = ready;
    end
    checks++;
    if (ta < 0) begin
      errors++;
      $display("[TB] FAIL %s seq_timeout: audio release not seen (tv=%0d tc=%0d)", tag, tv, tc);
    end
    checks++;
    if (tv < lo || tv > hi) begin
      errors++;
      $display("[TB] FAIL %s video_window: got cycle %0d, need [%0d,%0d]", tag, tv, lo, hi);
    end
    checks++;
    if (!(cv && cc && ca)) begin
      errors++;
      $display("[TB] FAIL %s ce3_align: ce_3m at releases v/c/a = %0b%0b%0b, need 111", tag, cv, cc, ca);
    end
    checks++;
    if (!((tc - tv == 12) || (tc - tv == 24))) begin
      errors++;
      $display("[TB] FAIL %s cpu_gap: got %0d, need 12 or 24", tag, tc - tv);
    end
    checks++;
    if (!((ta - tc == 12) || (ta - tc == 24))) begin
      errors++;
      $display("[TB] FAIL %s audio_gap: got %0d, need 12 or 24", tag, ta - tc);
    end
    checks++;
    if (tr != ta) begin
      errors++;
      $display("[TB] FAIL %s ready_align: ready rose %0d, audio released %0d", tag, tr, ta);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL %s order: %0d cycles violated release order, need 0", tag, bad);
    end
  endtask

  // Waits (bounded) for rst_video (which=0) or rst_cpu (which=1) to go low.
  task automatic wait_fall(input int which, input string tag, output int when);
    int n;
    n = 0;
    when = -1;
    while (when < 0 && n < 300) begin
      @(negedge clk_sys);
      n++;
      if ((which == 0 && rst_video == 1'b0) || (which == 1 && rst_cpu == 1'b0))
        when = cyc;
    end
    checks++;
    if (when < 0) begin
      errors++;
      $display("[TB] FAIL %s wait_timeout: release %0d not seen", tag, which);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; pll_locked = 1'b0; soft_rst = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (outs() !== 7'b1110000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b, need 1110000", outs());
    end
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      soft_rst = 1'($urandom_range(0, 1));
      @(negedge clk_sys);
      if (outs() !== 7'b1110000) bad++;
    end
    soft_rst = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL idle_no_lock: %0d cycles left idle state, need 0", bad);
    end
  endtask

  task automatic test_powerup();
    int t0;
    repeat ($urandom_range(3, 20)) @(negedge clk_sys);
    pll_locked = 1'b1;
    t0 = cyc + 1;
    check_sequence("powerup", t0 + SETTLE + SYNC, t0 + SETTLE + SYNC + 13);
  endtask

  task automatic test_strobes();
    int c12, c6, c3, misalign, last12, badgap, notready;
    c12 = 0; c6 = 0; c3 = 0; misalign = 0; last12 = -1; badgap = 0; notready = 0;
    repeat ($urandom_range(0, 11)) @(negedge clk_sys);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_sys);
      if (ce_12m) begin
        c12++;
        if (last12 >= 0 && cyc - last12 != 3) badgap++;
        last12 = cyc;
      end
      if (ce_6m) c6++;
      if (ce_3m) c3++;
      if ((ce_3m && !(ce_6m && ce_12m)) || (ce_6m && !ce_12m)) misalign++;
      if (!ready) notready++;
    end
    checks++;
    if (c12 != 40) begin errors++; $display("[TB] FAIL ce12_count: got %0d, need 40", c12); end
    checks++;
    if (c6 != 20) begin errors++; $display("[TB] FAIL ce6_count: got %0d, need 20", c6); end
    checks++;
    if (c3 != 10) begin errors++; $display("[TB] FAIL ce3_count: got %0d, need 10", c3); end
    checks++;
    if (misalign != 0) begin errors++; $display("[TB] FAIL ce_coincide: %0d misaligned cycles, need 0", misalign); end
    checks++;
    if (badgap != 0) begin errors++; $display("[TB] FAIL ce12_spacing: %0d bad gaps, need 0", badgap); end
    checks++;
    if (notready != 0) begin errors++; $display("[TB] FAIL run_ready: %0d cycles not ready, need 0", notready); end
  endtask

  task automatic test_lock_loss();
    int first, after_bad, t0;
    first = -1; after_bad = 0;
    repeat ($urandom_range(0, 11)) @(negedge clk_sys);
    pll_locked = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_sys);
      if (outs() === 7'b1110000) begin
        if (first < 0) first = i;
      end else if (first >= 0) begin
        after_bad++;
      end
    end
    checks++;
    if (first < 1 || first > 3) begin
      errors++;
      $display("[TB] FAIL lockloss_latency: reset after %0d cycles, need 1..3", first);
    end
    checks++;
    if (after_bad != 0) begin
      errors++;
      $display("[TB] FAIL lockloss_hold: %0d cycles left reset, need 0", after_bad);
    end
    pll_locked = 1'b1;
    t0 = cyc + 1;
    check_sequence("relock", t0 + SETTLE + SYNC, t0 + SETTLE + SYNC + 13);
  endtask

  task automatic test_soft_reset();
    int c12, f, tv;
    // Long request while running.
    repeat ($urandom_range(0, 11)) @(negedge clk_sys);
    soft_rst = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({rst_video, rst_cpu, rst_audio, ready} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL soft_run_reset: got %b, need 1110", {rst_video, rst_cpu, rst_audio, ready});
    end
    c12 = ce_12m ? 1 : 0;
    repeat (9) begin
      @(negedge clk_sys);
      if (ce_12m) c12++;
    end
    soft_rst = 1'b0;
    f = cyc;
    checks++;
    if (c12 < 3 || c12 > 4) begin
      errors++;
      $display("[TB] FAIL soft_ce_running: %0d ce_12m in 10 cycles, need 3..4", c12);
    end
    wait_fall(0, "soft_long", tv);
    checks++;
    if (tv < f + SETTLE || tv > f + SETTLE + 13) begin
      errors++;
      $display("[TB] FAIL soft_long_window: video release %0d, need [%0d,%0d]", tv, f + SETTLE, f + SETTLE + 13);
    end
    // Single-cycle request during the video-to-cpu gap.
    repeat ($urandom_range(0, 5)) @(negedge clk_sys);
    soft_rst = 1'b1;
    @(negedge clk_sys);
    soft_rst = 1'b0;
    f = cyc;
    checks++;
    if ({rst_video, rst_cpu, rst_audio, ready} !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL soft_gap_reset: got %b, need 1110", {rst_video, rst_cpu, rst_audio, ready});
    end
    check_sequence("soft_gap", f + SETTLE, f + SETTLE + 13);
  endtask

  task automatic test_async_rst();
    int tc, t0, bad;
    soft_rst = 1'b1;
    @(negedge clk_sys);
    soft_rst = 1'b0;
    wait_fall(1, "to_gap_a", tc);
    repeat ($urandom_range(0, 5)) @(negedge clk_sys);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 7'b1110000) begin
      errors++;
      $display("[TB] FAIL async_rst_immediate: got %b, need 1110000", outs());
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (outs() !== 7'b1110000) bad++;
    end
    rst = 1'b0;
    t0 = cyc + 1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL async_rst_hold: %0d cycles left reset, need 0", bad);
    end
    check_sequence("after_rst", t0 + SETTLE + SYNC, t0 + SETTLE + SYNC + 13);
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_strobes();
    test_lock_loss();
    test_strobes();
    test_soft_reset();
    test_async_rst();
    test_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
